scan_seq: RTL and testbench
===========================

# scan_seq

Timed scan sequencer that drives the select inputs `a`, `b`, `c` of the 3-to-8 one-hot decoder stage. It sits directly upstream of that decoder: it generates a 3-bit index that advances at a prescaled rate or on a manual step pulse. It supports up, down, bounce ("chaser") and hold modes, so the decoder's 8 outputs can scan LEDs or display digits.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per automatic advance; legal range 2..2^DIV_W.
- `DIV_W`, default 26: prescaler counter width; must satisfy 2^DIV_W >= TICK_DIV.
- `clk  in  1`: single clock, all state updates on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `en  in  1`: 1 enables automatic advance from the prescaler; 0 enables manual stepping.
- `mode  in  2`: 00 up, 01 down, 10 bounce, 11 hold.
- `step  in  1`: manual advance request, level input, rising-edge detected internally; honoured only when `en`=0.
- `a  out  1`: index bit 2 (MSB), to decoder `a`.
- `b  out  1`: index bit 1, to decoder `b`.
- `c  out  1`: index bit 0 (LSB), to decoder `c`.
- `idx  out  3`: the same index as a bus, {a,b,c}.
- `tick  out  1`: one-cycle pulse, high in the cycle in which the new index first appears.
- `wrap  out  1`: one-cycle pulse, coincident with `tick`, on wrap-around or bounce reversal.

## Operation
- Registers: `idx[2:0]`, direction state `dir` (UP/DOWN), prescaler `cnt[DIV_W-1:0]`, `step_q`, `tick`, `wrap`.
- Reset values: idx=0 (a=b=c=0), dir=UP, cnt=0, step_q=0, tick=0, wrap=0.
- Advance condition `adv`:
  - when `en`=1: cnt==TICK_DIV-1;
  - when `en`=0: step && !step_q.
  - `adv` is forced to 0 in hold mode.
- Prescaler:
  - when en=1 and mode!=hold, cnt increments and wraps to 0 at TICK_DIV-1;
  - otherwise cnt is cleared to 0.
- On `adv`, by mode:
  - Up: idx+1, modulo 8; wrap=1 on the 7→0 transition; dir←UP.
  - Down: idx-1, modulo 8; wrap=1 on the 0→7 transition; dir←DOWN.
  - Bounce: dir=UP steps idx+1; dir=DOWN steps idx-1.
    - On arriving at 7, dir←DOWN and wrap=1; on arriving at 0, dir←UP and wrap=1.
    - Endpoints are not repeated: sequence 0,1,…,7,6,…,0,1,…
    - Entering bounce with idx=7 and dir=UP: the next advance goes to 6 and sets dir←DOWN; wrap=0 (the reversal occurs at departure, not arrival). The mirror case applies with idx=0 and dir=DOWN.
  - Hold: idx and dir frozen; tick=wrap=0.
- `step_q` ← `step` every cycle regardless of mode or `en`, so a step already high when `en` falls does not trigger an advance.
- A mode change takes effect on the next `adv`; idx is never reset by a mode change.
- Outputs `a`, `b`, `c`, `idx` are direct register outputs with no combinational path from any input.

## Timing
- Auto mode: after reset with en=1, the first advance is visible TICK_DIV cycles after reset deasserts. Thereafter the period is exactly TICK_DIV cycles.
- Manual mode: a step rising edge sampled at edge N makes the new idx and `tick` visible after edge N (one-cycle latency).
- `tick`/`wrap` are high for exactly one cycle, aligned with the updated idx.
- `rst` asserted mid-scan: all registers return to reset values at that edge, overriding `adv`. The prescaler restarts, so the next auto advance comes TICK_DIV cycles after release.
- `en` toggling: cnt clears whenever en=0, so re-enabling always yields a full TICK_DIV period.
- rst and adv in the same cycle: rst wins.

## Structure
- Shared package/include `scan_defs`:
  - mode encodings MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_BOUNCE=2'b10, MODE_HOLD=2'b11;
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
- Sub-module `tick_gen`: the prescaler.
  - Parameters TICK_DIV and DIV_W; ports clk, rst, run, pulse.
  - pulse=1 when cnt==TICK_DIV-1 and run=1.
- Top module holds the edge detector, the index/direction FSM, and the output registers.
- Intended top-level pairing: scan_seq.{a,b,c} → decoder {a,b,c}.

## Test plan
- Reset, then en=1, mode=up, TICK_DIV=4 → idx 1 at cycle 4, 2 at cycle 8 … 7 at cycle 28, 0 at cycle 32 with wrap=1; tick every 4 cycles.
- mode=bounce, en=1, TICK_DIV=4, from reset → idx sequence 1,2,…,7,6,…,0,1; wrap only on arrival at 7 and at 0; no repeated endpoint.
- en=0, mode=down, step high for 3 cycles, then low, then high again → idx 0→7 (wrap=1) on the first edge only, then 7→6; no advance while step is held.
- mode=hold with en=1 for 20 cycles at idx=5 → idx stays 5, tick=0 throughout. Switch to up → idx 6 exactly 4 cycles later.
- rst asserted at idx=3 mid-period, coinciding with an advance → idx=0, tick=0, dir=UP after the edge; next advance exactly 4 cycles after release.
- Manual step with en=0 at idx=7, dir=UP, mode switched to bounce → idx=6, wrap=0, dir=DOWN.

Source files
------------

// File: rtl/scan_defs.sv
// Shared encodings for the scan sequencer: mode and direction types plus the index stepping helper.
package scan_defs;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [2:0] IDX_MIN = 3'd0;
    localparam logic [2:0] IDX_MAX = 3'd7;

    function automatic logic [2:0] idx_step(input logic [2:0] cur, input dir_e dir);
        return (dir == DIR_UP) ? cur + 3'd1 : cur - 3'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts while run=1 and emits a pulse on the last count of each TICK_DIV period.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIV_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic pulse
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             at_last_s;

    assign at_last_s = (cnt_q == CNT_LAST);
    assign pulse     = run && at_last_s;

    // Next count: stopping the prescaler clears it so a restart yields a full period.
    always_comb begin
        cnt_d = '0;
        if (!run) begin
            cnt_d = '0;
        end else if (at_last_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_seq.sv
// Scan sequencer: 3-bit index for a 3-to-8 decoder, advanced by the prescaler or a manual step edge.
module scan_seq
    import scan_defs::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIV_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       step,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] idx,
    output logic       tick,
    output logic       wrap
);

    mode_e      mode_s;
    logic       hold_s;
    logic       pulse_s;
    logic       adv_s;
    logic [2:0] bounce_nxt_s;

    logic [2:0] idx_q,  idx_d;
    dir_e       dir_q,  dir_d;
    logic       step_q;
    logic       tick_q, tick_d;
    logic       wrap_q, wrap_d;

    assign mode_s = mode_e'(mode);
    assign hold_s = (mode_s == MODE_HOLD);
    assign adv_s  = !hold_s && (en ? pulse_s : (step && !step_q));

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .run   (en && !hold_s),
        .pulse (pulse_s)
    );

    assign bounce_nxt_s = idx_step(idx_q, dir_q);

    // Index/direction next state; bounce reverses at departure when entered sitting on an endpoint.
    always_comb begin
        idx_d  = idx_q;
        dir_d  = dir_q;
        tick_d = adv_s;
        wrap_d = 1'b0;
        if (adv_s) begin
            case (mode_s)
                MODE_UP: begin
                    idx_d  = idx_q + 3'd1;
                    wrap_d = (idx_q == IDX_MAX);
                    dir_d  = DIR_UP;
                end
                MODE_DOWN: begin
                    idx_d  = idx_q - 3'd1;
                    wrap_d = (idx_q == IDX_MIN);
                    dir_d  = DIR_DOWN;
                end
                MODE_BOUNCE: begin
                    if (dir_q == DIR_UP && idx_q == IDX_MAX) begin
                        idx_d = idx_q - 3'd1;
                        dir_d = DIR_DOWN;
                    end else if (dir_q == DIR_DOWN && idx_q == IDX_MIN) begin
                        idx_d = idx_q + 3'd1;
                        dir_d = DIR_UP;
                    end else begin
                        idx_d = bounce_nxt_s;
                        if (bounce_nxt_s == IDX_MAX) begin
                            dir_d  = DIR_DOWN;
                            wrap_d = 1'b1;
                        end else if (bounce_nxt_s == IDX_MIN) begin
                            dir_d  = DIR_UP;
                            wrap_d = 1'b1;
                        end else begin
                            dir_d  = dir_q;
                        end
                    end
                end
                default: begin
                    idx_d  = idx_q;
                    dir_d  = dir_q;
                    tick_d = 1'b0;
                end
            endcase
        end else begin
            idx_d = idx_q;
            dir_d = dir_q;
        end
    end

    // State and output registers; reset overrides any pending advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= 3'd0;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            dir_q  <= dir_d;
            step_q <= step;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign a    = idx_q[2];
    assign b    = idx_q[1];
    assign c    = idx_q[0];
    assign idx  = idx_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_seq.sv
// Bench for scan_seq: per-cycle scoreboard against a behavioural model plus hand-derived segment checks.
module tb_scan_seq;
    import scan_defs::*;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       step = 1'b0;
    logic       a, b, c, tick, wrap;
    logic [2:0] idx;

    scan_seq #(.TICK_DIV(TD), .DIV_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
        .a(a), .b(b), .c(c), .idx(idx), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       step;
        int         ncyc;
        logic [2:0] e_idx;
        logic       e_tick;
        logic       e_wrap;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc_no = 0;

    int m_idx = 0;
    int m_cnt = 0;
    bit m_dir = 1'b0;
    bit m_stepq = 1'b0;

    task automatic add(input logic r, input logic e, input logic [1:0] m, input logic s,
                       input int n, input logic [2:0] ei, input logic et, input logic ew);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.step = s; v.ncyc = n;
        v.e_idx = ei; v.e_tick = et; v.e_wrap = ew;
        vecs.push_back(v);
    endtask

    // Behavioural reference: computes the state the DUT should show after the coming edge.
    task automatic model(input logic r, input logic e, input logic [1:0] m, input logic s);
        bit adv;
        bit w;
        int nxt;
        w = 1'b0;
        adv = 1'b0;
        if (r) begin
            m_idx = 0; m_cnt = 0; m_dir = 1'b0; m_stepq = 1'b0;
        end else begin
            if (m != MODE_HOLD) adv = e ? (m_cnt == TD - 1) : (s && !m_stepq);
            m_cnt   = (e && m != MODE_HOLD) ? ((m_cnt == TD - 1) ? 0 : m_cnt + 1) : 0;
            m_stepq = s;
            if (adv) begin
                if (m == MODE_UP) begin
                    w = (m_idx == 7); m_idx = (m_idx + 1) % 8; m_dir = 1'b0;
                end else if (m == MODE_DOWN) begin
                    w = (m_idx == 0); m_idx = (m_idx + 7) % 8; m_dir = 1'b1;
                end else begin
                    nxt = m_dir ? m_idx - 1 : m_idx + 1;
                    if (nxt > 7) begin
                        nxt = 6; m_dir = 1'b1;
                    end else if (nxt < 0) begin
                        nxt = 1; m_dir = 1'b0;
                    end else if (nxt == 7) begin
                        m_dir = 1'b1; w = 1'b1;
                    end else if (nxt == 0) begin
                        m_dir = 1'b0; w = 1'b1;
                    end
                    m_idx = nxt;
                end
            end
        end
        sb_q.push_back({3'(m_idx), adv, w});
    endtask

    task automatic cyc(input logic r, input logic e, input logic [1:0] m, input logic s);
        logic [4:0] exp_v;
        rst = r; en = e; mode = m; step = s;
        model(r, e, m, s);
        @(posedge clk);
        #1;
        cyc_no++;
        exp_v = sb_q.pop_front();
        n_cmp++;
        if ({idx, a, b, c, tick, wrap} !== {exp_v[4:2], exp_v[4:2], exp_v[1:0]}) begin
            n_bad++;
            $display("FAIL sb cycle %0d: got idx=%0d abc=%b%b%b tick=%b wrap=%b, want idx=%0d tick=%b wrap=%b",
                     cyc_no, idx, a, b, c, tick, wrap, exp_v[4:2], exp_v[1], exp_v[0]);
        end
        @(negedge clk);
    endtask

    initial begin
        int  gap;
        bit  found;
        // Segments: {rst, en, mode, step, cycles, idx, tick, wrap after the last cycle}
        add(1, 0, MODE_UP,     0,  2, 3'd0, 0, 0);
        add(0, 1, MODE_UP,     0, 32, 3'd0, 1, 1);
        add(0, 1, MODE_UP,     0,  4, 3'd1, 1, 0);
        add(0, 1, MODE_UP,     0, 16, 3'd5, 1, 0);
        add(0, 1, MODE_HOLD,   0, 20, 3'd5, 0, 0);
        add(0, 1, MODE_UP,     0,  3, 3'd5, 0, 0);
        add(0, 1, MODE_UP,     0,  1, 3'd6, 1, 0);
        add(0, 1, MODE_UP,     0, 20, 3'd3, 1, 0);
        add(0, 1, MODE_UP,     0,  3, 3'd3, 0, 0);
        add(1, 1, MODE_UP,     0,  1, 3'd0, 0, 0);
        add(0, 1, MODE_UP,     0,  3, 3'd0, 0, 0);
        add(0, 1, MODE_UP,     0,  1, 3'd1, 1, 0);
        add(1, 1, MODE_BOUNCE, 0,  1, 3'd0, 0, 0);
        add(0, 1, MODE_BOUNCE, 0, 28, 3'd7, 1, 1);
        add(0, 1, MODE_BOUNCE, 0,  4, 3'd6, 1, 0);
        add(0, 1, MODE_BOUNCE, 0, 24, 3'd0, 1, 1);
        add(0, 1, MODE_BOUNCE, 0,  4, 3'd1, 1, 0);
        add(1, 0, MODE_DOWN,   0,  2, 3'd0, 0, 0);
        add(0, 0, MODE_DOWN,   1,  1, 3'd7, 1, 1);
        add(0, 0, MODE_DOWN,   1,  2, 3'd7, 0, 0);
        add(0, 0, MODE_DOWN,   0,  1, 3'd7, 0, 0);
        add(0, 0, MODE_DOWN,   1,  1, 3'd6, 1, 0);
        add(0, 1, MODE_UP,     1,  2, 3'd6, 0, 0);
        add(0, 0, MODE_UP,     1,  2, 3'd6, 0, 0);
        add(0, 0, MODE_HOLD,   0,  1, 3'd6, 0, 0);
        add(0, 0, MODE_HOLD,   1,  1, 3'd6, 0, 0);
        add(0, 0, MODE_UP,     0,  1, 3'd6, 0, 0);
        add(0, 0, MODE_UP,     1,  1, 3'd7, 1, 0);
        add(0, 0, MODE_BOUNCE, 0,  1, 3'd7, 0, 0);
        add(0, 0, MODE_BOUNCE, 1,  1, 3'd6, 1, 0);
        add(0, 0, MODE_BOUNCE, 0,  1, 3'd6, 0, 0);
        add(0, 0, MODE_BOUNCE, 1,  1, 3'd5, 1, 0);
        for (int i = 0; i < 5; i++) begin
            add(0, 0, MODE_DOWN, 0, 1, 3'(5 - i), 0, 0);
            add(0, 0, MODE_DOWN, 1, 1, 3'(4 - i), 1, 0);
        end
        add(0, 0, MODE_BOUNCE, 0,  1, 3'd0, 0, 0);
        add(0, 0, MODE_BOUNCE, 1,  1, 3'd1, 1, 0);
        add(0, 0, MODE_BOUNCE, 0,  1, 3'd1, 0, 0);
        add(0, 0, MODE_BOUNCE, 1,  1, 3'd2, 1, 0);
        add(0, 1, MODE_UP,     0,  3, 3'd2, 0, 0);
        add(0, 1, MODE_UP,     0,  1, 3'd3, 1, 0);
        add(0, 1, MODE_UP,     0,  2, 3'd3, 0, 0);
        add(0, 0, MODE_UP,     0,  1, 3'd3, 0, 0);
        add(0, 1, MODE_UP,     0,  3, 3'd3, 0, 0);
        add(0, 1, MODE_UP,     0,  1, 3'd4, 1, 0);

        @(negedge clk);
        for (int v = 0; v < vecs.size(); v++) begin
            for (int k = 0; k < vecs[v].ncyc; k++) cyc(vecs[v].rst, vecs[v].en, vecs[v].mode, vecs[v].step);
            n_cmp++;
            if ({idx, tick, wrap} !== {vecs[v].e_idx, vecs[v].e_tick, vecs[v].e_wrap}) begin
                n_bad++;
                $display("FAIL row %0d: got idx=%0d tick=%b wrap=%b, want idx=%0d tick=%b wrap=%b",
                         v, idx, tick, wrap, vecs[v].e_idx, vecs[v].e_tick, vecs[v].e_wrap);
            end
        end

        // Auto period right after an advance must be exactly TD cycles.
        gap = 0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc(0, 1, MODE_UP, 0);
            gap++;
            if (tick) found = 1'b1;
        end
        n_cmp++;
        if (!found || gap != TD) begin
            n_bad++;
            $display("FAIL tick_period: got %0d cycles (seen=%0d), want %0d", gap, found, TD);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
